// File: rtl/trvk_tag_queue.sv
// trvk_tag_queue: in-order tracking queue for capability loads awaiting a
// revocation-bit lookup. Each capability load is enqueued with its destination
// register at writeback. Revocation results return in load order, and each one
// drives the register file's tag-clearing interface (trvk_*).
//
// All three RF write ports are snooped. A register that is overwritten after
// its load is therefore never tag-cleared.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   ld_valid_i, ld_addr_i  capability load writeback needing a revocation check
//   ld_ready_o             queue can accept an entry (not full)
//   rvk_valid_i            revocation result for the oldest entry
//   rvk_revoked_i          result says the capability is revoked
//   weN_i, waddrN_i        RF write port snoop (N = 0..2)
//   trvk_en_o              tag-clear interface valid (combinational)
//   trvk_clrtag_o          clear the tag of trvk_addr_o (combinational)
//   trvk_addr_o            register to clear (combinational)
//   count_o                current occupancy
//   err_o                  sticky overflow/underflow error
//   stat_clr_o             revoked clears issued (TRVK_QUEUE_STATS_EN only)
//   stat_sup_o             clears suppressed by overwrite (TRVK_QUEUE_STATS_EN only)
//
// Optional feature macro: TRVK_QUEUE_STATS_EN enables saturating 16-bit
// statistics counters. When it is undefined, both stat ports are tied to 0.
module trvk_tag_queue #(
    parameter int unsigned Depth     = 4,
    parameter bit          CHERIoTEn = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ld_valid_i,
    input  logic [4:0]                 ld_addr_i,
    output logic                       ld_ready_o,
    input  logic                       rvk_valid_i,
    input  logic                       rvk_revoked_i,
    input  logic                       we0_i,
    input  logic                       we1_i,
    input  logic                       we2_i,
    input  logic [4:0]                 waddr0_i,
    input  logic [4:0]                 waddr1_i,
    input  logic [4:0]                 waddr2_i,
    output logic                       trvk_en_o,
    output logic                       trvk_clrtag_o,
    output logic [4:0]                 trvk_addr_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       err_o,
    output logic [15:0]                stat_clr_o,
    output logic [15:0]                stat_sup_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [4:0]       addr_q [Depth];
    logic [Depth-1:0] live_q, live_d;
    logic [PW-1:0]    head_q, tail_q;
    logic             err_q;

    logic [AW-1:0] head_idx, tail_idx;
    logic          empty, full, enq, deq, hit;
    logic [4:0]    head_addr;
    logic          head_live;

    assign head_idx  = head_q[AW-1:0];
    assign tail_idx  = tail_q[AW-1:0];
    assign empty     = (head_q == tail_q);
    assign full      = (head_q[AW] != tail_q[AW]) && (head_idx == tail_idx);
    assign head_addr = addr_q[head_idx];
    assign head_live = live_q[head_idx];

    // The disabled queue sits in its reset state, so full stays 0 and ready stays 1.
    assign enq = CHERIoTEn && ld_valid_i && !full;
    assign deq = CHERIoTEn && rvk_valid_i && !empty;

    // A same-cycle write to the head register must not have its new data tag-cleared.
    assign hit = (we0_i && (waddr0_i == head_addr)) ||
                 (we1_i && (waddr1_i == head_addr)) ||
                 (we2_i && (waddr2_i == head_addr));

    assign ld_ready_o    = !full;
    assign trvk_en_o     = deq;
    assign trvk_clrtag_o = deq && rvk_revoked_i && head_live && !hit;
    assign trvk_addr_o   = (CHERIoTEn && !empty) ? head_addr : 5'd0;
    assign count_o       = CW'(tail_q - head_q);
    assign err_o         = err_q;

    // Snoop kill of existing entries. The entry enqueued this cycle is exempt,
    // because the load's own writeback appears on a write port in the same cycle.
    always_comb begin
        live_d = live_q;
        for (int i = 0; i < Depth; i++) begin
            if ((we0_i && (waddr0_i == addr_q[i])) ||
                (we1_i && (waddr1_i == addr_q[i])) ||
                (we2_i && (waddr2_i == addr_q[i]))) begin
                live_d[i] = 1'b0;
            end
        end
        if (enq) begin
            live_d[tail_idx] = (ld_addr_i != 5'd0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !CHERIoTEn) begin
            head_q <= '0;
            tail_q <= '0;
            live_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                addr_q[i] <= 5'd0;
            end
        end else begin
            live_q <= live_d;
            if (enq) begin
                addr_q[tail_idx] <= ld_addr_i;
                tail_q           <= tail_q + 1'b1;
            end
            if (deq) begin
                head_q <= head_q + 1'b1;
            end
            if ((ld_valid_i && full) || (rvk_valid_i && empty)) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef TRVK_QUEUE_STATS_EN
    logic [15:0] stat_clr_q, stat_sup_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !CHERIoTEn) begin
            stat_clr_q <= 16'd0;
            stat_sup_q <= 16'd0;
        end else begin
            if (trvk_clrtag_o && (stat_clr_q != 16'hFFFF)) begin
                stat_clr_q <= stat_clr_q + 16'd1;
            end
            if (trvk_en_o && rvk_revoked_i && !trvk_clrtag_o && (stat_sup_q != 16'hFFFF)) begin
                stat_sup_q <= stat_sup_q + 16'd1;
            end
        end
    end

    assign stat_clr_o = stat_clr_q;
    assign stat_sup_o = stat_sup_q;
`else
    assign stat_clr_o = 16'd0;
    assign stat_sup_o = 16'd0;
`endif

endmodule

// File: tb/tb_trvk_tag_queue.sv
// Self-checking bench for trvk_tag_queue.
// It runs directed scenarios followed by randomized traffic. All of it is
// checked against a queue-based reference model.
module tb_trvk_tag_queue;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld_v;
    logic [4:0] ld_a;
    logic       rv, rr;
    logic       we0, we1, we2;
    logic [4:0] wa0, wa1, wa2;

    logic        ld_ready, trvk_en, trvk_clr;
    logic [4:0]  trvk_addr;
    logic [2:0]  count;
    logic        err;
    logic [15:0] stat_clr, stat_sup;

    always #5 clk = ~clk;

    trvk_tag_queue #(
        .Depth    (DEPTH),
        .CHERIoTEn(1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ld_valid_i   (ld_v),
        .ld_addr_i    (ld_a),
        .ld_ready_o   (ld_ready),
        .rvk_valid_i  (rv),
        .rvk_revoked_i(rr),
        .we0_i        (we0),
        .we1_i        (we1),
        .we2_i        (we2),
        .waddr0_i     (wa0),
        .waddr1_i     (wa1),
        .waddr2_i     (wa2),
        .trvk_en_o    (trvk_en),
        .trvk_clrtag_o(trvk_clr),
        .trvk_addr_o  (trvk_addr),
        .count_o      (count),
        .err_o        (err),
        .stat_clr_o   (stat_clr),
        .stat_sup_o   (stat_sup)
    );

    typedef struct {
        logic [4:0] addr;
        logic       live;
    } ent_t;

    ent_t mq[$];
    bit   m_err;
    int   m_clr, m_sup;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit wr_match(input logic [4:0] a);
        return (we0 && wa0 == a) || (we1 && wa1 == a) || (we2 && wa2 == a);
    endfunction

    task automatic idle();
        ld_v = 0; ld_a = 0; rv = 0; rr = 0;
        we0 = 0; we1 = 0; we2 = 0; wa0 = 0; wa1 = 0; wa2 = 0;
    endtask

    // Compare the settled outputs with the model, advance the model and the clock,
    // and return with idle inputs shortly after the edge.
    task automatic tick();
        bit empty, full, exp_en, exp_clr;
        empty   = (mq.size() == 0);
        full    = (mq.size() == DEPTH);
        exp_en  = rv && !empty;
        exp_clr = exp_en && rr && mq[0].live && !wr_match(mq[0].addr);
        check_eq("ready", ld_ready, !full);
        check_eq("count", count, mq.size());
        check_eq("trvk_en", trvk_en, exp_en);
        check_eq("clrtag", trvk_clr, exp_clr);
        if (exp_en) check_eq("trvk_addr", trvk_addr, mq[0].addr);
        check_eq("err", err, m_err);
        check_eq("stat_clr", stat_clr, m_clr);
        check_eq("stat_sup", stat_sup, m_sup);
        if (!rst_n) begin
            mq.delete();
            m_err = 0; m_clr = 0; m_sup = 0;
        end else begin
            if ((ld_v && full) || (rv && empty)) m_err = 1;
`ifdef TRVK_QUEUE_STATS_EN
            if (exp_clr && m_clr < 65535) m_clr++;
            if (exp_en && rr && !exp_clr && m_sup < 65535) m_sup++;
`endif
            foreach (mq[i]) if (mq[i].live && wr_match(mq[i].addr)) mq[i].live = 0;
            if (exp_en) void'(mq.pop_front());
            if (ld_v && !full) mq.push_back('{addr: ld_a, live: (ld_a != 0)});
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2; tick();
        rst_n = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        #2;
        check_eq("rst_count", count, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ready", ld_ready, 1);
        tick();
        rst_n = 1;

        // Revoked result for addr 5 clears it on the same cycle.
        ld_v = 1; ld_a = 5; #2; tick();
        #2; tick();
        #2; tick();
        rv = 1; rr = 1; #2;
        check_eq("t1_en", trvk_en, 1);
        check_eq("t1_clr", trvk_clr, 1);
        check_eq("t1_addr", trvk_addr, 5);
        check_eq("t1_cnt1", count, 1);
        tick();
        #2; check_eq("t1_cnt0", count, 0); tick();

        // Overwrite after load suppresses the clear.
        ld_v = 1; ld_a = 7; #2; tick();
        we1 = 1; wa1 = 7; #2; tick();
        rv = 1; rr = 1; #2;
        check_eq("t2_en", trvk_en, 1);
        check_eq("t2_clr", trvk_clr, 0);
        check_eq("t2_addr", trvk_addr, 7);
        tick();

        // A second load to the same register kills the first entry only.
        ld_v = 1; ld_a = 3; we0 = 1; wa0 = 3; #2; tick();
        ld_v = 1; ld_a = 3; we0 = 1; wa0 = 3; #2; tick();
        rv = 1; rr = 1; #2; check_eq("t3_clr_a", trvk_clr, 0); tick();
        rv = 1; rr = 1; #2;
        check_eq("t3_clr_b", trvk_clr, 1);
        check_eq("t3_addr", trvk_addr, 3);
        tick();

        // Fill, overflow, then drain in order.
        for (int a = 1; a <= 4; a++) begin
            ld_v = 1; ld_a = 5'(a); #2; tick();
        end
        #2;
        check_eq("t4_ready", ld_ready, 0);
        check_eq("t4_cnt", count, 4);
        ld_v = 1; ld_a = 9; tick();
        #2;
        check_eq("t4_err", err, 1);
        check_eq("t4_cnt_hold", count, 4);
        tick();
        for (int a = 1; a <= 4; a++) begin
            rv = 1; rr = 0; #2;
            check_eq("t4_order", trvk_addr, 5'(a));
            tick();
        end

        // Same-cycle overwrite of the head, then underflow.
        do_reset();
        ld_v = 1; ld_a = 9; #2; tick();
        rv = 1; rr = 1; we2 = 1; wa2 = 9; #2;
        check_eq("t5_en", trvk_en, 1);
        check_eq("t5_clr", trvk_clr, 0);
        tick();
        rv = 1; rr = 1; #2; check_eq("t5_en_empty", trvk_en, 0); tick();
        #2; check_eq("t5_err", err, 1); tick();

        // Reset discards the outstanding entry, so the next result underflows.
        do_reset();
        ld_v = 1; ld_a = 6; #2; tick();
        do_reset();
        rv = 1; rr = 1; #2;
        check_eq("t6_cnt", count, 0);
        check_eq("t6_en", trvk_en, 0);
        tick();
        #2; check_eq("t6_err", err, 1); tick();

        // Randomized traffic over a small register range to provoke snoop hits.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            ld_v = ($urandom_range(0, 1) == 1);
            ld_a = 5'($urandom_range(0, 7));
            rv   = ($urandom_range(0, 9) < 4);
            rr   = ($urandom_range(0, 3) != 0);
            we0  = ($urandom_range(0, 3) == 0); wa0 = 5'($urandom_range(0, 7));
            we1  = ($urandom_range(0, 3) == 0); wa1 = 5'($urandom_range(0, 7));
            we2  = ($urandom_range(0, 3) == 0); wa2 = 5'($urandom_range(0, 7));
            #2; tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trvk_tag_queue.md
Name: trvk_tag_queue

Overview:
- In-order tracking queue for capability loads awaiting a revocation-bit lookup.
- Each capability load is enqueued with its destination register when it writes back. Revocation results return in load order.
- For each result, the block drives the register file's revocation tag-clearing interface (trvk_en/trvk_clrtag/trvk_addr).
- Snoops all three RF write ports so that a register overwritten after the load is never tag-cleared.

Parameters:
- Depth, 4, number of outstanding entries; power of two, 2..16.
- CHERIoTEn, 1'b1, when 0 the queue is inert: all trvk outputs 0, ld_ready_o=1, no state updates.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- ld_valid_i  in  1  capability load writing back this cycle; needs revocation check.
- ld_addr_i  in  5  destination register of that load.
- ld_ready_o  out  1  queue can accept an entry (= !full).
- rvk_valid_i  in  1  revocation result for the oldest entry.
- rvk_revoked_i  in  1  1 = capability revoked; clear tag.
- we0_i/we1_i/we2_i  in  1 each  RF write enables (snoop).
- waddr0_i/waddr1_i/waddr2_i  in  5 each  RF write addresses (snoop).
- trvk_en_o  out  1  tag-clear interface valid.
- trvk_clrtag_o  out  1  clear tag of trvk_addr_o.
- trvk_addr_o  out  5  register to clear.
- count_o  out  $clog2(Depth+1)  current occupancy.
- err_o  out  1  sticky protocol error (overflow or underflow).
- stat_clr_o  out  16  revoked clears issued (see Optional Feature).
- stat_sup_o  out  16  clears suppressed by overwrite (see Optional Feature).

Behaviour:
- Storage: circular buffer of Depth entries, each {addr[4:0], live}. Head/tail pointers have log2(Depth)+1 bits; full/empty are derived from MSB-differs/equal.
- All state updates on posedge clk_i.
- Reset (rst_ni=0 at posedge): pointers=0, all live=0, err_o=0, stats=0.
- Enqueue: ld_valid_i & ld_ready_o.
  - Writes {ld_addr_i, live = (ld_addr_i != 0)} at tail; tail++.
  - ld_valid_i & !ld_ready_o: entry dropped, err_o set.
- Dequeue: rvk_valid_i & !empty → head++.
  - rvk_valid_i & empty: ignored, err_o set, trvk outputs 0.
- Outputs are combinational; zero-cycle latency from rvk_valid_i:
  - trvk_en_o = rvk_valid_i & !empty.
  - trvk_addr_o = head.addr.
  - trvk_clrtag_o = trvk_en_o & rvk_revoked_i & head.live & !hit, where hit = any (weN_i & waddrN_i == head.addr) in the same cycle. The RF masks same-cycle write data with clrtag, so new data must be protected.
- Snoop kill: every cycle, any existing entry with live=1 and addr equal to an asserted waddrN_i gets live=0.
  - The entry being enqueued this cycle is exempt; the load's own write is on a write port in the same cycle.
  - Older entries with the same addr are killed by that same write.
- Simultaneous enqueue + dequeue:
  - Legal when not full; count_o unchanged.
  - When full, ld_ready_o=0; the dequeue frees a slot for the next cycle only.
- Dequeue + kill of head in the same cycle: the combinational hit already suppresses the clear; the entry leaves anyway.
- ld_addr_i=0: enqueued with live=0, so it consumes a result and never clears.
- count_o = tail − head.
- err_o is cleared only by reset.
- CHERIoTEn=0: state held at reset values; all outputs 0 except ld_ready_o=1.

Optional Feature:
- Macro: TRVK_QUEUE_STATS_EN.
- Defined:
  - stat_clr_o increments each cycle trvk_clrtag_o=1.
  - stat_sup_o increments each cycle trvk_en_o & rvk_revoked_i & !trvk_clrtag_o.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- Enqueue addr 5, 2 idle cycles, rvk_valid=1 revoked=1 → same cycle trvk_en=1, clrtag=1, addr=5; count 1→0.
- Enqueue addr 7, next cycle we1=1 waddr1=7, then revoked result → trvk_en=1, clrtag=0, addr=7; stat_sup_o=1 with macro.
- Enqueue 3 then 3 again (second kills first), results revoked, revoked → first: clrtag=0; second: clrtag=1, addr=3.
- Fill Depth=4 (addrs 1,2,3,4) → ld_ready_o=0, count_o=4; extra ld_valid → err_o=1, still 4 entries; 4 results return addrs 1,2,3,4 in order.
- Head addr 9, revoked result with we2=1 waddr2=9 same cycle → clrtag=0; rvk_valid with empty queue → err_o=1, trvk_en=0.
- Enqueue addr 6, assert rst_ni=0 for one cycle, then rvk_valid → count_o=0, trvk_en=0, err_o=1 (underflow after reset).
